// File: rtl/host_cmd_hub.sv
// host_cmd_hub: turns a UART byte stream into capture-core commands and returns status/result bytes
// Ports: clk, resetn (synchronous, active-low)
//   rx_data/rx_valid: received bytes; rx_drop pulses when a byte arrives while busy outside payload collection
//   tx_data/tx_valid/tx_ready: response bytes, tx_valid held until accepted
//   cmd/cmd_strobe/reg_in0..7: command and input registers to the core
//   reg_out0..7/cap_status: core results and status (bit0 idle, bit3 ack); busy high whenever not idle
module host_cmd_hub #(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] cmd,
  output logic       cmd_strobe,
  output logic [7:0] reg_in0,
  output logic [7:0] reg_in1,
  output logic [7:0] reg_in2,
  output logic [7:0] reg_in3,
  output logic [7:0] reg_in4,
  output logic [7:0] reg_in5,
  output logic [7:0] reg_in6,
  output logic [7:0] reg_in7,
  input  logic [7:0] reg_out0,
  input  logic [7:0] reg_out1,
  input  logic [7:0] reg_out2,
  input  logic [7:0] reg_out3,
  input  logic [7:0] reg_out4,
  input  logic [7:0] reg_out5,
  input  logic [7:0] reg_out6,
  input  logic [7:0] reg_out7,
  input  logic [7:0] cap_status,
  output logic       busy,
  output logic       rx_drop
);
  localparam int TMAX = ACK_TIMEOUT > BYTE_TIMEOUT ? ACK_TIMEOUT : BYTE_TIMEOUT;
  localparam int CW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, PAYLOAD, ISSUE, WAIT_ACK, SEND, RELEASE, WAIT_CLR} state_t;
  state_t state, state_n;
  logic [7:0] opcode, err, status_snap;
  logic [7:0][7:0] regs, outs, snap;
  logic [2:0] idx;
  logic [3:0] tx_idx, tx_len;
  logic [CW-1:0] cnt;
  logic ack_to, byte_to, tx_last, is_cmd;
  assign outs = {reg_out7, reg_out6, reg_out5, reg_out4, reg_out3, reg_out2, reg_out1, reg_out0};
  assign {reg_in7, reg_in6, reg_in5, reg_in4, reg_in3, reg_in2, reg_in1, reg_in0} = regs;
  assign busy = state != IDLE;
  assign cmd_strobe = state == ISSUE || state == RELEASE;
  assign tx_valid = state == SEND;
  // err is nonzero only for the single-byte EE/EF responses, which replace the status byte
  assign tx_data = !tx_valid ? 8'h00 : tx_idx == 4'd0 ? (err != 8'h00 ? err : status_snap) : snap[3'(tx_idx - 4'd1)];
  assign rx_drop = rx_valid && !(state == IDLE || (state == PAYLOAD && !byte_to));
  always_comb begin
    // cnt starts at 0 on state entry, so firing at T-1 means T full clocks were spent waiting
    ack_to = cnt == CW'(ACK_TIMEOUT - 1);
    byte_to = cnt == CW'(BYTE_TIMEOUT - 1);
    is_cmd = rx_data inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h09};
    tx_len = err != 8'h00 ? 4'd1 : opcode == 8'h05 ? 4'd9 : opcode == 8'h06 ? 4'd5 : opcode == 8'h07 ? 4'd3 : 4'd1;
    tx_last = tx_ready && tx_idx == tx_len - 4'd1;
    state_n = state;
    case (state)
      IDLE:     if (rx_valid) state_n = (rx_data == 8'h03 || rx_data == 8'h04) ? PAYLOAD : is_cmd ? ISSUE : SEND;
      PAYLOAD:  state_n = byte_to ? IDLE : (rx_valid && idx == 3'd7) ? ISSUE : PAYLOAD;
      ISSUE:    state_n = WAIT_ACK;
      WAIT_ACK: state_n = (cap_status[3] || ack_to) ? SEND : WAIT_ACK;
      SEND:     if (tx_last) state_n = err != 8'h00 ? IDLE : RELEASE;
      RELEASE:  state_n = WAIT_CLR;
      WAIT_CLR: state_n = (!cap_status[3] || ack_to) ? IDLE : WAIT_CLR;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      tx_idx <= '0;
      opcode <= '0;
      err <= '0;
      status_snap <= '0;
      snap <= '0;
      regs <= '0;
      cmd <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || (state == PAYLOAD && rx_valid)) ? '0 : cnt == '1 ? cnt : cnt + CW'(1);
      tx_idx <= state != SEND ? 4'd0 : tx_idx + {3'b0, tx_ready};
      if (state == IDLE && rx_valid) begin
        opcode <= rx_data;
        err <= state_n == SEND ? 8'hEE : 8'h00;
        idx <= '0;
      end
      if (state == PAYLOAD && rx_valid && !byte_to) begin
        regs[idx] <= rx_data;
        idx <= idx + 3'd1;
      end
      if (state == WAIT_ACK && cap_status[3]) begin
        status_snap <= cap_status;
        snap <= outs;
      end
      if (state == WAIT_ACK && !cap_status[3] && ack_to) err <= 8'hEF;
      if (state_n == ISSUE) cmd <= state == IDLE ? rx_data : opcode;
      if (state_n == RELEASE) cmd <= 8'h08;
    end
  end
endmodule

// File: tb/tb_host_cmd_hub.sv
// tb_host_cmd_hub: directed self-checking bench for host_cmd_hub with a small core/transmitter responder
module tb_host_cmd_hub;
  logic clk = 0;
  logic resetn = 0;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1;
  logic [7:0] cmd;
  logic cmd_strobe;
  logic [7:0] ri0, ri1, ri2, ri3, ri4, ri5, ri6, ri7;
  logic [7:0][7:0] ro = '0;
  logic [7:0] cap_status = 8'h01;
  logic busy, rx_drop;
  int passed = 0, total = 0;
  int cyc = 0, strobes = 0, rel = 0, drops = 0, unstable = 0, ack_cnt = 0, ack_delay = 3, wc = 0;
  int t_strobe = 0, t_tx = -1, n;
  logic ack_en = 1, slow = 0, hold = 0;
  logic [7:0] hold_data = 0, last_cmd = 0, core_status = 8'h09;
  logic [63:0] strobe_regs = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  host_cmd_hub #(.ACK_TIMEOUT(50), .BYTE_TIMEOUT(20)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd(cmd), .cmd_strobe(cmd_strobe),
    .reg_in0(ri0), .reg_in1(ri1), .reg_in2(ri2), .reg_in3(ri3),
    .reg_in4(ri4), .reg_in5(ri5), .reg_in6(ri6), .reg_in7(ri7),
    .reg_out0(ro[0]), .reg_out1(ro[1]), .reg_out2(ro[2]), .reg_out3(ro[3]),
    .reg_out4(ro[4]), .reg_out5(ro[5]), .reg_out6(ro[6]), .reg_out7(ro[7]),
    .cap_status(cap_status), .busy(busy), .rx_drop(rx_drop)
  );

  function automatic logic [63:0] regs_now();
    return {ri0, ri1, ri2, ri3, ri4, ri5, ri6, ri7};
  endfunction

  function automatic logic [71:0] txq_packed();
    logic [71:0] v = '0;
    foreach (txq[i]) v = {v[63:0], txq[i]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Samples the cycle before the edge, advances one clock, then plays the core and transmitter.
  task automatic tick();
    logic acc, rel_now;
    #1;
    acc = tx_valid && tx_ready;
    if (acc) txq.push_back(tx_data);
    if (hold && (!tx_valid || tx_data !== hold_data)) unstable++;
    hold = tx_valid && !tx_ready;
    hold_data = tx_data;
    if (tx_valid && t_tx < 0) t_tx = cyc;
    if (rx_drop) drops++;
    rel_now = cmd_strobe && cmd == 8'h08;
    if (rel_now) rel++;
    if (cmd_strobe && !rel_now) begin
      strobes++;
      last_cmd = cmd;
      strobe_regs = regs_now();
      t_strobe = cyc;
      if (ack_en) ack_cnt = ack_delay;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rel_now) cap_status = 8'h01;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) cap_status = core_status;
    end
    if (slow) begin
      if (acc) wc = 0;
      else if (tx_valid) wc++;
      tx_ready = wc >= 10;
    end else tx_ready = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick();
    rx_valid = 0;
  endtask

  task automatic start_test(input logic is_slow);
    txq.delete();
    strobes = 0;
    rel = 0;
    drops = 0;
    unstable = 0;
    hold = 0;
    t_tx = -1;
    slow = is_slow;
    wc = 0;
    tx_ready = !is_slow;
  endtask

  task automatic wait_idle(input int max);
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_data", tx_data, 0);
    check("reset cmd", cmd, 0);
    check("reset cmd_strobe", cmd_strobe, 0);
    check("reset rx_drop", rx_drop, 0);
    check("reset reg_in", regs_now(), 0);
    resetn = 1;
    tick();

    start_test(0);
    core_status = 8'h09;
    send_byte(8'h04);
    send_byte(8'h6E); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h14); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("cfg strobe", cmd_strobe, 1);
    check("cfg cmd", cmd, 8'h04);
    check("cfg reg_in", regs_now(), 64'h6E00_0000_1400_0000);
    wait_idle(40);
    check("cfg idle", busy, 0);
    check("cfg strobes", strobes, 1);
    check("cfg strobe regs", strobe_regs, 64'h6E00_0000_1400_0000);
    check("cfg tx", {txq.size(), txq_packed()}, {32'd1, 72'h09});
    check("cfg release", rel, 1);
    check("cfg ack latency", t_tx - t_strobe, 4);

    start_test(0);
    ro = '0;
    ro[0] = 8'h48;
    ro[4] = 8'h5A;
    send_byte(8'h06);
    check("size strobe latency", cmd_strobe, 1);
    check("size cmd", cmd, 8'h06);
    wait_idle(40);
    check("size tx", {txq.size(), txq_packed()}, {32'd5, 72'h09_4800_0000});
    check("size release", rel, 1);
    check("size ack latency", t_tx - t_strobe, 4);

    start_test(1);
    for (int i = 0; i < 8; i++) ro[i] = 8'(i + 1);
    send_byte(8'h05);
    wait_idle(300);
    check("data idle", busy, 0);
    check("data tx", {txq.size(), txq_packed()}, {32'd9, 72'h09_0102_0304_0506_0708});
    check("data stable", unstable, 0);
    check("data release", rel, 1);

    start_test(0);
    send_byte(8'h0B);
    check("bad op tx_valid", tx_valid, 1);
    check("bad op tx_data", tx_data, 8'hEE);
    wait_idle(10);
    check("bad op idle", busy, 0);
    check("bad op tx", {txq.size(), txq_packed()}, {32'd1, 72'hEE});
    check("bad op strobes", strobes + rel, 0);

    start_test(0);
    ack_en = 0;
    send_byte(8'h01);
    tick();
    send_byte(8'h55);
    check("timeout drop", drops, 1);
    wait_idle(100);
    check("timeout idle", busy, 0);
    check("timeout tx", {txq.size(), txq_packed()}, {32'd1, 72'hEF});
    check("timeout latency", t_tx - t_strobe, 51);
    check("timeout release", rel, 0);
    check("timeout cmd", last_cmd, 8'h01);
    ack_en = 1;

    start_test(0);
    send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_idle(40);
    check("stall cycles", n, 20);
    check("stall idle", busy, 0);
    check("stall no strobe", strobes + rel, 0);
    check("stall no tx", txq.size(), 0);
    check("stall reg_in", regs_now(), 64'hAABB_CC00_1400_0000);

    send_byte(8'h04);
    for (int i = 0; i < 19; i++) tick();
    rx_data = 8'h77;
    rx_valid = 1;
    #1;
    check("edge timeout drop", rx_drop, 1);
    tick();
    rx_valid = 0;
    check("edge timeout idle", busy, 0);
    check("edge timeout reg_in0", ri0, 8'hAA);

    start_test(1);
    send_byte(8'h05);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("mid-send reached", tx_valid, 1);
    resetn = 0;
    tick();
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_data", tx_data, 0);
    check("reset busy", busy, 0);
    check("reset cmd", cmd, 0);
    check("reset strobe", cmd_strobe, 0);
    check("reset reg_in", regs_now(), 0);
    resetn = 1;
    ack_cnt = 0;
    cap_status = 8'h01;
    start_test(0);
    tick();
    tick();
    check("post reset quiet", {busy, tx_valid, cmd_strobe}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/host_cmd_hub.md
Name: host_cmd_hub

Overview:
Synthesizable host-side command hub that sits directly upstream of the logic-capture core and replaces the simulation command stub.
- Parses a byte stream from the UART receiver into opcodes plus 8-byte payloads.
- Loads the core's eight input registers, strobes the command, and waits for the core's ack.
- Returns a status byte plus result bytes to the UART transmitter, then issues the ACK command to release the core.

Parameters:
ACK_TIMEOUT, 1000000, clocks to wait for cap_status[3] after a strobe (or for it to clear after CMD_ACK) before aborting
BYTE_TIMEOUT, 100000, maximum clocks between payload bytes before the packet is discarded

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle pulse, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts when tx_valid&tx_ready at clk edge
cmd  out  8  command code to core
cmd_strobe  out  1  one-cycle command strobe to core
reg_in0..reg_in7  out  8 each  core input registers
reg_out0..reg_out7  in  8 each  core output registers
cap_status  in  8  core status; bit0 idle, bit3 ack
busy  out  1  high whenever state != IDLE
rx_drop  out  1  one-cycle pulse: rx byte discarded because busy outside PAYLOAD

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; cmd=0x00; cmd_strobe=0; reg_in0..7=0x00; tx_valid=0; tx_data=0x00; busy=0; rx_drop=0; all counters cleared. Reset mid-transaction aborts silently; no response byte is sent.
- Opcodes: 01 START, 02 ABORT, 03 TRIGGER_CONFIGURE, 04 BUFFER_CONFIGURE, 05 READ_TRACE_DATA, 06 READ_TRACE_SIZE, 07 READ_TRIGGER_SAMPLE, 08 ACK, 09 RESET.
- IDLE, on rx_valid:
  - Opcode 03 or 04 -> PAYLOAD, byte index 0.
  - Opcode 01, 02, 05, 06, 07 or 09 -> ISSUE.
  - Any other value (00, 08, >=0A) -> SEND with a single byte 0xEE. No strobe is issued.
- PAYLOAD:
  - Each rx_valid writes reg_in[idx] (reg_in0 first) and increments idx. After idx 7 -> ISSUE.
  - The idle counter resets on every byte. When it reaches BYTE_TIMEOUT -> IDLE with no response; reg_in keeps its partial contents.
- ISSUE: cmd=opcode and cmd_strobe=1 for exactly one cycle -> WAIT_ACK. For non-configure opcodes reg_in holds its previous values.
- WAIT_ACK:
  - On cap_status[3]=1, snapshot cap_status and reg_out0..7 into shadow registers on the same edge -> SEND.
  - After ACK_TIMEOUT clocks without ack -> SEND with single byte 0xEF. No CMD_ACK follows; go to IDLE afterwards.
- SEND: response = status snapshot byte, then data bytes.
  - 05: reg_out0..7 (total 9 bytes).
  - 06: reg_out0..3 (total 5 bytes).
  - 07: reg_out0..1 (total 3 bytes).
  - Others: status byte only (1 byte).
  - tx_valid=1 with tx_data stable until tx_valid&tx_ready. The next byte is presented the cycle after acceptance; the hub never drops tx_valid while a byte is pending.
  - After the last byte -> RELEASE (or IDLE for 0xEE/0xEF).
- RELEASE: cmd=0x08 and cmd_strobe=1 for one cycle -> WAIT_CLR.
- WAIT_CLR: wait for cap_status[3]=0 -> IDLE. On ACK_TIMEOUT, go to IDLE with no extra byte.
- cmd holds its last value between strobes.
- rx_valid in any state other than IDLE/PAYLOAD: byte discarded, rx_drop=1 for that cycle.
- rx_valid in the same cycle a timeout fires in PAYLOAD: the timeout wins and the byte is dropped (rx_drop=1).
- Timeout counters are ceil(log2(max param+1)) bits wide, saturate, and clear on every state entry.
- Latency: opcode byte accepted at edge N -> cmd_strobe high in cycle N+1 (no-payload opcodes). Ack seen at edge M -> tx_valid high in cycle M+1.

Test Plan:
- Send 04 then 6E 00 00 00 14 00 00 00; core acks 3 clocks after strobe with status 0x09 -> reg_in0..7=6E,00,00,00,14,00,00,00 at the strobe, cmd=04, tx bytes {09}, then one CMD_ACK strobe, busy drops after ack clears.
- Send 06; core returns reg_out0..3=48,00,00,00, status 0x09 -> tx {09,48,00,00,00}, then CMD_ACK strobe.
- Send 05 with tx_ready held low for 10 cycles per byte; reg_out0..7=01..08 -> 9 bytes in order {st,01..08}, tx_data stable while tx_valid&~tx_ready.
- Send 0x0B -> tx {EE}, cmd_strobe never asserted, busy back low after the byte is accepted.
- Send 01 with no ack (ACK_TIMEOUT=50) -> tx {EF} at about 51 clocks, no CMD_ACK; extra rx byte during WAIT_ACK -> rx_drop pulse.
- Send 03 plus 3 bytes then stall (BYTE_TIMEOUT=20) -> return to IDLE with no strobe and no tx. Then reset asserted mid-SEND -> tx_valid=0 next cycle and all outputs at reset values.
